popcount_accum_tern: RTL and testbench

Streaming, parametrised popcount accumulator for ternary printed-NN neurons. It is the sequential successor of the fixed 11-input combinational popcount blocks.
- Accepts WIDTH-bit activation words over a valid/ready handshake and popcounts each word, exactly or approximately.
- Accumulates the counts across a multi-beat frame.
- At frame end, emits the sum and a ternary neuron decision against programmable thresholds.

---
 rtl/popcount_accum_tern_pkg.sv | 20 ++
 rtl/popcount_accum_tern_if.sv | 34 +++
 rtl/popcount_accum_tern_core.sv | 34 +++
 rtl/popcount_accum_tern.sv | 187 ++++++++++++++++++
 tb/tb_popcount_accum_tern.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/popcount_accum_tern_pkg.sv
// Shared definitions for the streaming ternary popcount accumulator:
// trit encodings, FSM state type and the per-beat count width helper.
package popcount_pkg;

    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Bits needed to hold a popcount of 0..width
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/popcount_accum_tern_if.sv
// Stream interface of the popcount accumulator: input beat channel,
// per-frame configuration and result channel.
interface popcount_accum_tern_if #(
    parameter int WIDTH = 11,
    parameter int ACC_W = 8
);
    logic             mode;
    logic [ACC_W-1:0] thr_hi;
    logic [ACC_W-1:0] thr_lo;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [1:0]       out_trit;
    logic             out_sat;
    logic             out_ovf;

    // Producer / consumer side
    modport master (
        output mode, thr_hi, thr_lo, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_trit, out_sat, out_ovf
    );

    // Accumulator side
    modport slave (
        input  mode, thr_hi, thr_lo, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_trit, out_sat, out_ovf
    );
endinterface

// File: rtl/popcount_accum_tern_core.sv
// Combinational per-word popcount. Exact count, or the count floored to a
// multiple of 2^TRUNC in approximate mode. Future approximate netlists
// plug in behind the mode select.
module popcount_core
    import popcount_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int TRUNC = 1
) (
    input  logic [WIDTH-1:0]        data,
    input  logic                    mode,
    output logic [cnt_w(WIDTH)-1:0] count
);
    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] cnt_exact;
    logic [CW-1:0] trunc_mask;

    // Exact popcount: sum of all lanes
    always_comb begin
        cnt_exact = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_exact = cnt_exact + CW'(data[i]);
        end
    end

    // Mask that clears the TRUNC least significant count bits
    for (genvar gi = 0; gi < CW; gi++) begin : g_mask
        assign trunc_mask[gi] = (gi >= TRUNC);
    end

    assign count = mode ? (cnt_exact & trunc_mask) : cnt_exact;

endmodule

// File: rtl/popcount_accum_tern.sv
// Streaming popcount accumulator for ternary neurons. Beats are popcounted
// (stage 1), added into a saturating accumulator (stage 2), and at frame
// end the sum plus a ternary decision are presented until consumed.
module popcount_accum_tern
    import popcount_pkg::*;
#(
    parameter int WIDTH     = 11,
    parameter int MAX_BEATS = 16,
    parameter int TRUNC     = 1,
    parameter int ACC_W     = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    popcount_accum_tern_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int SW = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
    localparam logic [BW-1:0]    LAST_BEAT = BW'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cnt_vld_q, cnt_vld_d;
    logic             mode_q, mode_d;
    logic [ACC_W-1:0] thr_hi_q, thr_hi_d;
    logic [ACC_W-1:0] thr_lo_q, thr_lo_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [1:0]       out_trit_q, out_trit_d;
    logic             out_sat_q, out_sat_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             first_beat;
    logic             at_limit;
    logic             core_mode;
    logic [CW-1:0]    beat_cnt;
    logic [SW-1:0]    sum_ext;
    logic [1:0]       trit_now;

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_trit  = out_trit_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_ovf   = out_ovf_q;

    assign accept     = bus.in_valid && (state_q == ACC);
    assign first_beat = (beat_q == '0);
    assign at_limit   = (beat_q == LAST_BEAT);
    // The first beat already uses the live mode, later beats the captured one
    assign core_mode  = first_beat ? bus.mode : mode_q;
    assign sum_ext    = {1'b0, acc_q} + SW'(cnt_q);

    popcount_core #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_core (
        .data  (bus.in_data),
        .mode  (core_mode),
        .count (beat_cnt)
    );

    // Ternary decision on the settled accumulator; +1 wins over -1
    always_comb begin
        if (acc_q >= thr_hi_q) begin
            trit_now = TRIT_POS;
        end else if (acc_q < thr_lo_q) begin
            trit_now = TRIT_NEG;
        end else begin
            trit_now = TRIT_ZERO;
        end
    end

    // Next-state: count pipeline, saturating accumulate and frame FSM
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        cnt_vld_d   = 1'b0;
        mode_d      = mode_q;
        thr_hi_d    = thr_hi_q;
        thr_lo_d    = thr_lo_q;
        sat_d       = sat_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_trit_d  = out_trit_q;
        out_sat_d   = out_sat_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            cnt_d     = beat_cnt;
            cnt_vld_d = 1'b1;
            beat_d    = beat_q + BW'(1);
            if (first_beat) begin
                mode_d   = bus.mode;
                thr_hi_d = bus.thr_hi;
                thr_lo_d = bus.thr_lo;
            end
        end

        if (cnt_vld_q) begin
            if (sum_ext > SW'(ACC_MAX)) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else begin
                acc_d = sum_ext[ACC_W-1:0];
            end
        end

        case (state_q)
            ACC: begin
                if (accept && (bus.in_last || at_limit)) begin
                    state_d = DRAIN;
                    ovf_d   = !bus.in_last;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_q;
                    out_trit_d  = trit_now;
                    out_sat_d   = sat_q;
                    out_ovf_d   = ovf_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                    acc_d       = '0;
                    beat_d      = '0;
                    sat_d       = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            beat_q      <= '0;
            cnt_q       <= '0;
            cnt_vld_q   <= 1'b0;
            mode_q      <= 1'b0;
            thr_hi_q    <= '0;
            thr_lo_q    <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_trit_q  <= TRIT_ZERO;
            out_sat_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            cnt_vld_q   <= cnt_vld_d;
            mode_q      <= mode_d;
            thr_hi_q    <= thr_hi_d;
            thr_lo_q    <= thr_lo_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_trit_q  <= out_trit_d;
            out_sat_q   <= out_sat_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_popcount_accum_tern.sv
// Scoreboard bench: two accumulators (ACC_W = 8 and ACC_W = 7) run in
// lockstep on the same stream; expected frames come from a plain
// arithmetic model and are checked by an independent monitor.
module tb_popcount_accum_tern;
    import popcount_pkg::*;

    localparam int WIDTH     = 11;
    localparam int MAX_BEATS = 16;
    localparam int TRUNC     = 1;

    typedef struct {
        int sum8;
        int trit8;
        int sat8;
        int sum7;
        int trit7;
        int sat7;
        int ovf;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    popcount_accum_tern_if #(.WIDTH(WIDTH), .ACC_W(8)) if_a ();
    popcount_accum_tern_if #(.WIDTH(WIDTH), .ACC_W(7)) if_b ();

    assign if_b.mode      = if_a.mode;
    assign if_b.thr_hi    = if_a.thr_hi[6:0];
    assign if_b.thr_lo    = if_a.thr_lo[6:0];
    assign if_b.in_valid  = if_a.in_valid;
    assign if_b.in_data   = if_a.in_data;
    assign if_b.in_last   = if_a.in_last;
    assign if_b.out_ready = if_a.out_ready;

    popcount_accum_tern #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS), .TRUNC(TRUNC), .ACC_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    popcount_accum_tern #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS), .TRUNC(TRUNC), .ACC_W(7)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int nframes = 0;
    exp_t sb_q[$];
    exp_t cur;
    bit have_cur = 0;
    logic [WIDTH-1:0] fr_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int trit_of(input int s, input int hi, input int lo);
        if (s >= hi) return 1;
        if (s < lo) return 3;
        return 0;
    endfunction

    // Issue one beat and return just after the edge that accepted it
    task automatic send_beat(input logic [WIDTH-1:0] d, input bit last, input bit md,
                             input logic [7:0] hi, input logic [7:0] lo);
        int w;
        if_a.in_valid = 1'b1;
        if_a.in_data  = d;
        if_a.in_last  = last;
        if_a.mode     = md;
        if_a.thr_hi   = hi;
        if_a.thr_lo   = lo;
        w = 0;
        @(negedge clk);
        while (!if_a.in_ready) begin
            w++;
            if (w > 500) begin
                $display("FAIL in_ready_timeout: in_ready stuck at 0, expected 1 within 500 cycles");
                $fatal(1, "input handshake never completed");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if_a.in_valid = 1'b0;
        if_a.in_last  = 1'b0;
        if_a.in_data  = WIDTH'($urandom);
    endtask

    // Send the frame held in fr_data and queue its expected result
    task automatic run_frame(input bit md, input logic [7:0] hi, input logic [7:0] lo,
                             input bit use_last);
        int n, total, pc, g;
        bit bm;
        logic [7:0] bh, bl;
        exp_t e;
        n = fr_data.size();
        total = 0;
        foreach (fr_data[i]) begin
            pc = $countones(fr_data[i]);
            total += md ? (pc - (pc % (1 << TRUNC))) : pc;
        end
        e.sum8  = (total > 255) ? 255 : total;
        e.sat8  = (total > 255) ? 1 : 0;
        e.sum7  = (total > 127) ? 127 : total;
        e.sat7  = (total > 127) ? 1 : 0;
        e.trit8 = trit_of(e.sum8, int'(hi), int'(lo));
        e.trit7 = trit_of(e.sum7, int'(hi) % 128, int'(lo) % 128);
        e.ovf   = use_last ? 0 : 1;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                bm = md; bh = hi; bl = lo;
            end else begin
                bm = 1'($urandom_range(0, 1));
                bh = 8'($urandom_range(0, 127));
                bl = 8'($urandom_range(0, 127));
            end
            send_beat(fr_data[i], use_last && (i == n - 1), bm, bh, bl);
            g = $urandom_range(0, 3);
            if (i < n - 1 && g > 1) begin
                repeat (g - 1) begin @(posedge clk); #1; end
            end
        end
        e.cyc = acc_cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((sb_q.size() != 0 || have_cur || if_a.out_valid) && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (w >= 400) begin
            errors++;
            $display("FAIL drain_timeout: pending results %0d expected 0", sb_q.size());
        end
    endtask

    // Consumer: random acceptance with occasional 5-cycle stalls
    initial begin
        bit lvl;
        int len;
        if_a.out_ready = 1'b0;
        forever begin
            lvl = ($urandom_range(0, 3) != 0);
            len = lvl ? $urandom_range(1, 3) : 5;
            repeat (len) begin
                @(posedge clk);
                #1;
                if_a.out_ready = lvl;
            end
        end
    end

    // Monitor: compares every presented result against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_cur = 0;
            end else if (if_a.out_valid || if_b.out_valid) begin
                if (!have_cur) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", int'(if_a.out_valid || if_b.out_valid), 0);
                    end else begin
                        cur = sb_q.pop_front();
                        have_cur = 1;
                        chk("latency", cyc - cur.cyc, 2);
                    end
                end
                if (have_cur) begin
                    chk("valid_a", int'(if_a.out_valid), 1);
                    chk("valid_b", int'(if_b.out_valid), 1);
                    chk("sum8", int'(if_a.out_sum), cur.sum8);
                    chk("trit8", int'(if_a.out_trit), cur.trit8);
                    chk("sat8", int'(if_a.out_sat), cur.sat8);
                    chk("ovf8", int'(if_a.out_ovf), cur.ovf);
                    chk("sum7", int'(if_b.out_sum), cur.sum7);
                    chk("trit7", int'(if_b.out_trit), cur.trit7);
                    chk("sat7", int'(if_b.out_sat), cur.sat7);
                    chk("ovf7", int'(if_b.out_ovf), cur.ovf);
                    chk("in_ready_hold", int'(if_a.in_ready), 0);
                    if (if_a.out_ready) begin
                        $display("frame %0d: sum8=%0d trit8=%0d sat8=%0d sum7=%0d sat7=%0d ovf=%0d",
                                 nframes, if_a.out_sum, if_a.out_trit, if_a.out_sat,
                                 if_b.out_sum, if_b.out_sat, if_a.out_ovf);
                        nframes++;
                        have_cur = 0;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        bit ul;
        if_a.in_valid = 1'b0;
        if_a.in_data  = '0;
        if_a.in_last  = 1'b0;
        if_a.mode     = 1'b0;
        if_a.thr_hi   = 8'd0;
        if_a.thr_lo   = 8'd0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(if_a.out_valid), 0);
        chk("rst_out_sum", int'(if_a.out_sum), 0);
        chk("rst_out_trit", int'(if_a.out_trit), 0);
        chk("rst_out_sat", int'(if_a.out_sat), 0);
        chk("rst_out_ovf", int'(if_a.out_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(if_a.in_ready), 1);
        @(posedge clk);
        #1;

        // Exact single beat, positive trit
        fr_data = {11'h7FF};
        run_frame(1'b0, 8'd8, 8'd3, 1'b1);
        // Approximate vs exact three-beat frame
        fr_data = {11'h007, 11'h007, 11'h007};
        run_frame(1'b1, 8'd8, 8'd3, 1'b1);
        run_frame(1'b0, 8'd8, 8'd3, 1'b1);
        // Force-closed frame, saturating in the narrow accumulator
        fr_data.delete();
        repeat (MAX_BEATS) fr_data.push_back(11'h7FF);
        run_frame(1'b0, 8'd8, 8'd3, 1'b0);
        // Negative and zero trit
        fr_data = {11'h003};
        run_frame(1'b0, 8'd8, 8'd3, 1'b1);
        fr_data = {11'h01F};
        run_frame(1'b0, 8'd8, 8'd3, 1'b1);
        // in_last on the final allowed beat
        fr_data.delete();
        repeat (MAX_BEATS) fr_data.push_back(WIDTH'($urandom));
        run_frame(1'b1, 8'd40, 8'd20, 1'b1);

        // Random frames
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, MAX_BEATS);
            ul = (n < MAX_BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
            fr_data.delete();
            for (int i = 0; i < n; i++) fr_data.push_back(WIDTH'($urandom));
            run_frame(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)),
                      8'($urandom_range(0, 127)), ul);
        end

        // Reset in the middle of a frame discards it
        wait_idle();
        send_beat(11'h7FF, 1'b0, 1'b0, 8'd8, 8'd3);
        send_beat(11'h7FF, 1'b0, 1'b0, 8'd8, 8'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(if_a.out_valid), 0);
        chk("midrst_out_sum", int'(if_a.out_sum), 0);
        chk("midrst_out_trit", int'(if_a.out_trit), 0);
        chk("midrst_out_sat", int'(if_b.out_sat), 0);
        chk("midrst_out_ovf", int'(if_a.out_ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("postrst_no_valid", int'(if_a.out_valid), 0);
            chk("postrst_in_ready", int'(if_a.in_ready), 1);
        end
        @(posedge clk);
        #1;
        fr_data = {11'h00F};
        run_frame(1'b0, 8'd8, 8'd3, 1'b1);

        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
